// File: rtl/ula_md.sv
// ula_md -- registered MIPS-style ALU with an iterative multiply/divide unit.
//
// Single-cycle opcodes complete one clock after acceptance. mult/multu/div/divu
// run a radix-2 shift-add / restoring-divide loop for WIDTH cycles and then
// write the HI/LO registers.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request, accepted only while busy=0
//   operation  5-bit opcode
//   in1, in2   operands A (rs) and B (rt/immediate)
//   shamt      constant shift amount
//   busy       multi-cycle operation in progress
//   done       one-cycle pulse: result/zero_flag valid
//   result     registered result
//   zero_flag  registered (result == 0)
//   hi, lo     HI/LO registers
//   overflow   (only with ULA_MD_OVF_EN) signed overflow of add (02) / sub (06)
//
// Optional feature macro: ULA_MD_OVF_EN adds the overflow output.

module ula_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       operation,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef ULA_MD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    // Iteration datapath: acc = partial product high half / partial remainder,
    // quo = multiplier (shifted out) / dividend (shifted out, quotient in),
    // opd = multiplicand / divisor. Operands are held as magnitudes; signs are
    // reapplied when the loop finishes.
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] opd_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic             is_div_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div0_reg;

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0] alu_sum;
    logic [WIDTH-1:0] alu_diff;
    logic [WIDTH-1:0] alu_res;
    logic             slt_bit;
    logic             sltu_bit;

    always_comb begin
        alu_sum  = in1 + in2;
        alu_diff = in1 - in2;
        slt_bit  = $signed(in1) < $signed(in2);
        sltu_bit = in1 < in2;
        case (operation)
            5'h00:   alu_res = in1 & in2;
            5'h01:   alu_res = in1 | in2;
            5'h03:   alu_res = in2 << shamt;
            5'h04:   alu_res = $signed(in2) >>> shamt;
            5'h05:   alu_res = in2 >> shamt;
            5'h06:   alu_res = alu_diff;
            5'h07:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            5'h08:   alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
            5'h0A:   alu_res = $signed(in2) >>> in1[SHW-1:0];
            5'h0B:   alu_res = {in2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            5'h0C:   alu_res = ~(in1 | in2);
            5'h0D:   alu_res = in1 ^ in2;
            5'h0E:   alu_res = in2 << in1[SHW-1:0];
            5'h0F:   alu_res = in2 >> in1[SHW-1:0];
            5'h14:   alu_res = hi_reg;
            5'h15:   alu_res = lo_reg;
            5'h16:   alu_res = in1;
            5'h17:   alu_res = in1;
            default: alu_res = alu_sum;   // 02, 09, 18-1F (10-13 never use it)
        endcase
    end

`ifdef ULA_MD_OVF_EN
    logic ovf_reg;
    logic ovf_next;

    always_comb begin
        ovf_next = 1'b0;
        if (operation == 5'h02)
            ovf_next = (in1[WIDTH-1] == in2[WIDTH-1]) && (alu_sum[WIDTH-1] != in1[WIDTH-1]);
        else if (operation == 5'h06)
            ovf_next = (in1[WIDTH-1] != in2[WIDTH-1]) && (alu_diff[WIDTH-1] != in1[WIDTH-1]);
    end

    assign overflow = ovf_reg;
`endif

    // ---------------- multi-cycle operand preparation ----------------
    logic             is_multi;
    logic             op_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        is_multi  = (operation[4:2] == 3'b100);
        op_signed = (operation == 5'h10) || (operation == 5'h12);
        sign_a    = op_signed & in1[WIDTH-1];
        sign_b    = op_signed & in2[WIDTH-1];
        mag_a     = sign_a ? -in1 : in1;
        mag_b     = sign_b ? -in2 : in2;
    end

    // ---------------- one iteration step ----------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ok;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_quo;

    always_comb begin
        mul_sum   = {1'b0, acc_reg} + (quo_reg[0] ? {1'b0, opd_reg} : {(WIDTH+1){1'b0}});
        div_shift = {acc_reg, quo_reg[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, opd_reg};
        // When div_ok the difference is below the divisor, so WIDTH bits suffice.
        div_sub   = div_shift[WIDTH-1:0] - opd_reg;
        if (is_div_reg) begin
            step_acc = div_ok ? div_sub : div_shift[WIDTH-1:0];
            step_quo = {quo_reg[WIDTH-2:0], div_ok};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_quo = {mul_sum[0], quo_reg[WIDTH-1:1]};
        end
    end

    // ---------------- sign fix-up on the final step ----------------
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    always_comb begin
        prod     = {step_acc, step_quo};
        prod_fix = neg_q_reg ? -prod : prod;
        if (is_div_reg) begin
            if (div0_reg) begin
                fin_lo = {WIDTH{1'b1}};
                fin_hi = dvd_reg;
            end else begin
                // MIN / -1 falls out naturally: |MIN| / 1 = MIN with positive sign.
                fin_lo = neg_q_reg ? -step_quo : step_quo;
                fin_hi = neg_r_reg ? -step_acc : step_acc;
            end
        end else begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
            acc_reg    <= '0;
            quo_reg    <= '0;
            opd_reg    <= '0;
            dvd_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
`ifdef ULA_MD_OVF_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_RUN: begin
                    acc_reg <= step_acc;
                    quo_reg <= step_quo;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg  <= S_FIN;
                        cnt_reg    <= '0;
                        done_reg   <= 1'b1;
                        hi_reg     <= fin_hi;
                        lo_reg     <= fin_lo;
                        result_reg <= fin_lo;
                        zero_reg   <= (fin_lo == '0);
`ifdef ULA_MD_OVF_EN
                        ovf_reg    <= 1'b0;
`endif
                    end
                end
                default: begin
                    // IDLE and FIN both accept a new request.
                    state_reg <= S_IDLE;
                    if (start) begin
                        if (is_multi) begin
                            state_reg  <= S_RUN;
                            cnt_reg    <= '0;
                            acc_reg    <= '0;
                            quo_reg    <= mag_a;
                            opd_reg    <= mag_b;
                            dvd_reg    <= in1;
                            is_div_reg <= operation[1];
                            neg_q_reg  <= sign_a ^ sign_b;
                            neg_r_reg  <= sign_a & operation[1];
                            div0_reg   <= (in2 == '0);
                        end else begin
                            done_reg   <= 1'b1;
                            result_reg <= alu_res;
                            zero_reg   <= (alu_res == '0);
`ifdef ULA_MD_OVF_EN
                            ovf_reg    <= ovf_next;
`endif
                            if (operation == 5'h16)
                                hi_reg <= in1;
                            if (operation == 5'h17)
                                lo_reg <= in1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = (state_reg == S_RUN);
    assign done      = done_reg;
    assign result    = result_reg;
    assign zero_flag = zero_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

endmodule

// File: tb/tb_ula_md.sv
// Testbench for ula_md: a WIDTH=32 instance driven through a scoreboard, and a
// WIDTH=16 instance for the parameterised/overflow steps.

module tb_ula_md;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [4:0]  operation = '0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, zero_flag;
    logic [31:0] result, hi, lo;

    logic        s16_start = 1'b0;
    logic [4:0]  s16_op = '0;
    logic [15:0] s16_in1 = '0;
    logic [15:0] s16_in2 = '0;
    logic [3:0]  s16_shamt = '0;
    logic        s16_busy, s16_done, s16_zero;
    logic [15:0] s16_result, s16_hi, s16_lo;
`ifdef ULA_MD_OVF_EN
    logic        ovf32, ovf16;
`endif

    ula_md #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
        .in1(in1), .in2(in2), .shamt(shamt), .busy(busy), .done(done),
        .result(result), .zero_flag(zero_flag), .hi(hi), .lo(lo)
`ifdef ULA_MD_OVF_EN
        , .overflow(ovf32)
`endif
    );

    ula_md #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16_start), .operation(s16_op),
        .in1(s16_in1), .in2(s16_in2), .shamt(s16_shamt), .busy(s16_busy), .done(s16_done),
        .result(s16_result), .zero_flag(s16_zero), .hi(s16_hi), .lo(s16_lo)
`ifdef ULA_MD_OVF_EN
        , .overflow(ovf16)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zf;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operands, tracking HI/LO.
    task automatic model(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input bit push);
        exp_t        e;
        logic [31:0] r;
        logic [63:0] p;
        longint      la, lb;
        int          sa, sbv;
        e.lat = 0;
        r = a + b;
        case (op)
            5'h00: r = a & b;
            5'h01: r = a | b;
            5'h03: r = b << sh;
            5'h04: r = $signed(b) >>> sh;
            5'h05: r = b >> sh;
            5'h06: r = a - b;
            5'h07: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h08: r = (a < b) ? 32'd1 : 32'd0;
            5'h0A: r = $signed(b) >>> a[4:0];
            5'h0B: r = {b[15:0], 16'h0000};
            5'h0C: r = ~(a | b);
            5'h0D: r = a ^ b;
            5'h0E: r = b << a[4:0];
            5'h0F: r = b >> a[4:0];
            5'h14: r = m_hi;
            5'h15: r = m_lo;
            5'h16: begin m_hi = a; r = a; end
            5'h17: begin m_lo = a; r = a; end
            5'h10, 5'h11: begin
                if (op == 5'h10) begin
                    la = $signed(a);
                    lb = $signed(b);
                    p  = la * lb;
                end else begin
                    p = {32'h0, a} * {32'h0, b};
                end
                m_hi = p[63:32];
                m_lo = p[31:0];
                r = m_lo;
                e.lat = W;
            end
            5'h12, 5'h13: begin
                if (b == 32'h0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == 5'h12 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'h0;
                end else if (op == 5'h12) begin
                    sa = a;
                    sbv = b;
                    m_lo = sa / sbv;
                    m_hi = sa % sbv;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                r = m_lo;
                e.lat = W;
            end
            default: r = a + b;
        endcase
        e.tag = tag;
        e.res = r;
        e.zf  = (r == 32'h0);
        e.hi  = m_hi;
        e.lo  = m_lo;
        if (push) sb.push_back(e);
    endtask

    task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input bit push = 1'b1);
        start = 1'b1;
        operation = op;
        in1 = a;
        in2 = b;
        shamt = sh;
        model(tag, op, a, b, sh, push);
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for done, then checks the oldest scoreboard entry.
    // skip = cycles of this operation already elapsed before the call.
    task automatic expect_done(input int skip = 0);
        exp_t e;
        int   n = 0;
        int   bc = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) bc++;
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            total++;
            failed++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_done"}, 64'(done), 64'd1);
            chk({e.tag, "_latency"}, 64'(n), 64'(e.lat - skip));
            chk({e.tag, "_busy_cycles"}, 64'(bc), 64'(e.lat - skip));
            chk({e.tag, "_busy_at_done"}, 64'(busy), 64'd0);
            chk({e.tag, "_result"}, 64'(result), 64'(e.res));
            chk({e.tag, "_zero"}, 64'(zero_flag), 64'(e.zf));
            chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
            $display("txn %s result=%h zero=%0b hi=%h lo=%h cycles=%0d", e.tag, result, zero_flag, hi, lo, n);
        end
    endtask

    task automatic issue16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        s16_start = 1'b1;
        s16_op = op;
        s16_in1 = a;
        s16_in2 = b;
        tick();
        s16_start = 1'b0;
    endtask

    initial begin
        int n;
        int dc;

        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero_flag), 64'd1);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_done", 64'(done), 64'd0);

        // ---------------- single-cycle ops ----------------
        issue("sub_eq", 5'h06, 32'd5, 32'd5, 5'd0);                 expect_done();
        issue("sra", 5'h04, 32'h0, 32'h8000_0000, 5'd4);             expect_done();
        issue("and", 5'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);     expect_done();
        issue("or", 5'h01, 32'hF000_0001, 32'h0000_1000, 5'd0);      expect_done();
        issue("add_wrap", 5'h02, 32'hFFFF_FFFF, 32'h1, 5'd0);        expect_done();
        issue("add_09", 5'h09, 32'd10, 32'd20, 5'd0);                expect_done();
        issue("add_1f", 5'h1F, 32'h1234_0000, 32'h0000_5678, 5'd0);  expect_done();
        issue("sll", 5'h03, 32'h0, 32'h1, 5'd31);                    expect_done();
        issue("srl", 5'h05, 32'h0, 32'h8000_0000, 5'd31);            expect_done();
        issue("slt", 5'h07, 32'hFFFF_FFFF, 32'h1, 5'd0);             expect_done();
        issue("sltu", 5'h08, 32'hFFFF_FFFF, 32'h1, 5'd0);            expect_done();
        issue("srav", 5'h0A, 32'h0000_0024, 32'h8000_0000, 5'd0);    expect_done();
        issue("lui", 5'h0B, 32'h0, 32'h1234_ABCD, 5'd0);             expect_done();
        issue("nor", 5'h0C, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);     expect_done();
        issue("xor", 5'h0D, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);     expect_done();
        issue("sllv", 5'h0E, 32'h0000_0023, 32'h1, 5'd0);            expect_done();
        issue("srlv", 5'h0F, 32'h4, 32'hF0, 5'd0);                   expect_done();

        // ---------------- multiply / divide ----------------
        issue("mult_neg", 5'h10, 32'hFFFF_FFFD, 32'd7, 5'd0);        expect_done();
        issue("mfhi", 5'h14, 32'h0, 32'h0, 5'd0);                    expect_done();
        issue("mflo", 5'h15, 32'h0, 32'h0, 5'd0);                    expect_done();
        issue("multu_max", 5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0); expect_done();
        issue("mult_min", 5'h10, 32'h8000_0000, 32'h8000_0000, 5'd0); expect_done();
        issue("div_neg", 5'h12, 32'hFFFF_FFF9, 32'd2, 5'd0);         expect_done();
        issue("divu_zero", 5'h13, 32'h1234, 32'h0, 5'd0);            expect_done();
        issue("div_ovf", 5'h12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0); expect_done();
        issue("div_negdiv", 5'h12, 32'd7, 32'hFFFF_FFFE, 5'd0);      expect_done();
        issue("div_zero", 5'h12, 32'hFFFF_FFFB, 32'h0, 5'd0);        expect_done();
        issue("divu", 5'h13, 32'd100, 32'd7, 5'd0);                  expect_done();
        issue("mthi", 5'h16, 32'hCAFE_0001, 32'h0, 5'd0);            expect_done();
        issue("mtlo", 5'h17, 32'hBEEF_0002, 32'h0, 5'd0);            expect_done();
        issue("mfhi2", 5'h14, 32'h0, 32'h0, 5'd0);                   expect_done();
        issue("mflo2", 5'h15, 32'h0, 32'h0, 5'd0);                   expect_done();

        // ---------------- handshake: start during RUN is ignored ----------------
        issue("mult_ign", 5'h11, 32'd1000, 32'd3000, 5'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("run_busy", 64'(busy), 64'd1);
        start = 1'b1;
        operation = 5'h02;
        in1 = 32'h1;
        in2 = 32'h1;
        tick();
        start = 1'b0;
        expect_done(6);
        // Start issued in the FIN cycle is accepted.
        issue("add_in_fin", 5'h02, 32'h100, 32'h23, 5'd0);
        expect_done();
        tick();
        chk("no_extra_done", 64'(done), 64'd0);

        // ---------------- async reset mid-RUN ----------------
        issue("multu_abort", 5'h11, 32'hFFFF, 32'hFFFF, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_zero", 64'(zero_flag), 64'd1);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        tick();
        tick();
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dc++;
            tick();
        end
        chk("arst_no_done", 64'(dc), 64'd0);
        issue("mflo_after_rst", 5'h15, 32'h0, 32'h0, 5'd0);          expect_done();

        // ---------------- WIDTH=16 instance ----------------
        issue16(5'h02, 16'h7FFF, 16'h0001);
        chk("w16_add_done", 64'(s16_done), 64'd1);
        chk("w16_add_result", 64'(s16_result), 64'h8000);
`ifdef ULA_MD_OVF_EN
        chk("w16_add_ovf", 64'(ovf16), 64'd1);
`endif
        issue16(5'h02, 16'h0001, 16'h0001);
        chk("w16_add2_result", 64'(s16_result), 64'h0002);
`ifdef ULA_MD_OVF_EN
        chk("w16_add2_ovf", 64'(ovf16), 64'd0);
`endif
        issue16(5'h06, 16'h8000, 16'h0001);
        chk("w16_sub_result", 64'(s16_result), 64'h7FFF);
`ifdef ULA_MD_OVF_EN
        chk("w16_sub_ovf", 64'(ovf16), 64'd1);
`endif
        issue16(5'h09, 16'h7FFF, 16'h0001);
        chk("w16_add09_result", 64'(s16_result), 64'h8000);
`ifdef ULA_MD_OVF_EN
        chk("w16_add09_ovf", 64'(ovf16), 64'd0);
`endif
        issue16(5'h17, 16'hABCD, 16'h0000);
        chk("w16_mtlo_result", 64'(s16_result), 64'hABCD);
        issue16(5'h15, 16'h0000, 16'h0000);
        chk("w16_mflo_result", 64'(s16_result), 64'hABCD);
        chk("w16_mflo_zero", 64'(s16_zero), 64'd0);
        issue16(5'h10, 16'hFFFD, 16'h0007);
        n = 0;
        while (s16_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("w16_mult_latency", 64'(n), 64'd16);
        chk("w16_mult_busy", 64'(s16_busy), 64'd0);
        chk("w16_mult_hi", 64'(s16_hi), 64'hFFFF);
        chk("w16_mult_lo", 64'(s16_lo), 64'hFFEB);
        chk("w16_mult_result", 64'(s16_result), 64'hFFEB);
        $display("txn w16 mult result=%h hi=%h lo=%h cycles=%0d", s16_result, s16_hi, s16_lo, n);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ula_md.md
Name: ula_md

Overview:
- Parametrised, registered successor of the single-cycle MIPS ALU.
- Keeps the full single-cycle operation set with operand width generalised to WIDTH.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/done handshake.
- Sits in the EX stage; the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >=8.
- SHW, $clog2(WIDTH), width of shamt and of the variable-shift amount taken from in1[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  operation request; accepted only when busy=0.
- operation  input  5  opcode, see Behaviour.
- in1  input  WIDTH  operand A (rs).
- in2  input  WIDTH  operand B (rt/immediate).
- shamt  input  SHW  constant shift amount.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse: result/zero_flag valid.
- result  output  WIDTH  registered result.
- zero_flag  output  1  registered, equals (result==0); updated only with result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; busy=0, done=0, result=0, zero_flag=1, hi=0, lo=0; iteration counter=0. Reset mid-operation aborts the operation; no done is issued.
- Single-cycle opcodes, all with 1-cycle latency (accepted on edge k, done=1 during cycle k+1, result/zero_flag updated at edge k):
  - 00 and; 01 or; 02 add; 03 sll in2<<shamt; 04 sra in2>>>shamt; 05 srl in2>>shamt.
  - 06 sub; 07 slt signed; 08 sltu unsigned; 0A srav in2>>>in1[SHW-1:0]; 0B lui {in2[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 0C nor; 0D xor; 0E sllv; 0F srlv (both use in1[SHW-1:0]).
  - 14 mfhi result=hi; 15 mflo result=lo; 16 mthi hi=in1, result=in1; 17 mtlo lo=in1, result=in1.
  - 09 and 18-1F: add.
  - Add/sub wrap modulo 2^WIDTH. slt/sltu produce 1 or 0, zero-extended.
- Multi-cycle opcodes: 10 mult (signed), 11 multu, 12 div (signed), 13 divu.
- FSM states and transitions:
  - IDLE -> RUN on an accepted multi-cycle start; operands latched on that edge.
  - RUN: busy=1 for exactly WIDTH cycles; one shift-add (mult) or restoring-subtract (div) step per cycle; counter counts 0..WIDTH-1.
  - RUN -> FIN when counter=WIDTH-1. FIN: busy=0, done=1; hi/lo/result/zero_flag visible. FIN -> IDLE.
  - A start in FIN is accepted normally.
  - Net latency: start at edge k, done during cycle k+WIDTH+1.
- Results:
  - mult/multu: {hi,lo} = full 2*WIDTH-bit product.
  - div/divu: lo = quotient, hi = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
  - For all four ops, result = lo.
- Divide by zero: lo = all ones, hi = dividend. Signed overflow (MIN / -1): lo = MIN, hi = 0. Both still take WIDTH+1 cycles.
- start while busy=1 is ignored: no state change, no done. start=0 leaves result, hi and lo held.
- done is never high in two consecutive cycles unless back-to-back starts are accepted.

Optional Feature:
- Macro ULA_MD_OVF_EN.
- When defined: extra output port overflow (1 bit), registered alongside result. It is 1 on signed two's-complement overflow of opcodes 02 and 06, and 0 for all other opcodes. Reset value 0.
- When undefined: the port and its logic are absent; add/sub behaviour is otherwise identical.

Test Plan:
- Reset/async: drive rst_n low mid-RUN of a multu -> busy=0, done=0, hi=lo=result=0 and zero_flag=1 immediately, without waiting for a clk edge; no done after release.
- Single-cycle: WIDTH=32, op 06, in1=5, in2=5 -> next cycle done=1, result=0, zero_flag=1. Op 04, in2=0x80000000, shamt=4 -> result=0xF8000000.
- mult: op 10, in1=-3 (0xFFFFFFFD), in2=7 -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB, result=lo; busy high for exactly 32 cycles.
- div signed/edge: op 12, in1=-7, in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Op 13, in2=0, in1=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
- Handshake: during RUN pulse start with op 02 -> ignored, result unchanged. Start issued in the FIN cycle is accepted, and its done follows one cycle later.
- Param/feature: WIDTH=16 with ULA_MD_OVF_EN, op 02, in1=0x7FFF, in2=1 -> result=0x8000, overflow=1. Op 17 then 15 with in1=0xABCD -> result=0xABCD.
